mult_arbiter: RTL and testbench

Shares one instance of the team's combinational `multiplier` datapath among `num_req` requesters. Requests are granted round-robin, one operation at a time. Each operation passes through a three-state sequencer: accept, compute, respond. The block sits between requesting engines and the multiplier, and owns the operand and result registers around it.

---
 rtl/mult_arbiter.sv | 139 +++++++++++++
 tb/tb_mult_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one combinational multiplier
// among num_req requesters. Each operation walks IDLE -> CALC -> RESP,
// with operand registers feeding the multiplier and a result register
// holding the product until the owning requester accepts it.

module multiplier #(
  parameter int bit_width = 8
) (
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  output logic [bit_width-1:0] product
);

  // Product truncated to the operand width (mod 2^bit_width).
  assign product = a * b;

endmodule

module mult_arbiter #(
  parameter int bit_width = 8,
  parameter int num_req   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*bit_width-1:0]  req_a,
  input  logic [num_req*bit_width-1:0]  req_b,
  output logic [num_req-1:0]            req_ready,
  output logic [num_req-1:0]            resp_valid,
  input  logic [num_req-1:0]            resp_ready,
  output logic [bit_width-1:0]          resp_result,
  output logic                          busy
);

  localparam int ptr_w = $clog2(num_req);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [ptr_w-1:0]     ptr;
  logic [ptr_w-1:0]     owner;
  logic [bit_width-1:0] a_p0;
  logic [bit_width-1:0] b_p0;
  logic [bit_width-1:0] result_p1;
  logic [num_req-1:0]   vld_p1;

  logic [bit_width-1:0] a_arr [num_req];
  logic [bit_width-1:0] b_arr [num_req];
  logic [bit_width-1:0] mult_out;
  logic [ptr_w-1:0]     grant_id;
  logic                 grant_hit;

  // Index base+off wrapped into 0..num_req-1; both inputs are below num_req.
  function automatic logic [ptr_w-1:0] wrap(input logic [ptr_w-1:0] base,
                                            input int off);
    logic [ptr_w:0] s;
    s = {1'b0, base} + (ptr_w+1)'(off);
    if (s >= (ptr_w+1)'(num_req))
      s = s - (ptr_w+1)'(num_req);
    return s[ptr_w-1:0];
  endfunction

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int k = 0; k < num_req; k++) begin
      a_arr[k] = req_a[k*bit_width +: bit_width];
      b_arr[k] = req_b[k*bit_width +: bit_width];
    end
  end

  // Round-robin scan from ptr; descending loop so the closest requester wins.
  always_comb begin
    grant_id  = '0;
    grant_hit = 1'b0;
    req_ready = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      if (req_valid[wrap(ptr, k)]) begin
        grant_id  = wrap(ptr, k);
        grant_hit = 1'b1;
      end
    end
    if (state == IDLE && !rst && grant_hit)
      req_ready[grant_id] = 1'b1;
  end

  multiplier #(
    .bit_width (bit_width)
  ) u_multiplier (
    .a       (a_p0),
    .b       (b_p0),
    .product (mult_out)
  );

  // Sequencer: grant/latch in IDLE, capture product in CALC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      result_p1 <= '0;
      vld_p1    <= '0;
    end else begin
      case (state)
        // p0 boundary: operands of the granted requester enter the datapath
        IDLE: begin
          if (grant_hit) begin
            a_p0  <= a_arr[grant_id];
            b_p0  <= b_arr[grant_id];
            owner <= grant_id;
            ptr   <= wrap(grant_id, 1);
            state <= CALC;
          end
        end
        // p1 boundary: multiplier output captured into the result register
        CALC: begin
          result_p1     <= mult_out;
          vld_p1[owner] <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (resp_ready[owner]) begin
            vld_p1 <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid  = vld_p1;
  assign resp_result = result_p1;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter (bit_width=8, num_req=4): directed scenarios
// plus a randomized run against a round-robin reference model.

module tb_mult_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [7:0]  resp_result;
  logic        busy;

  int n_cmp;
  int n_err;

  mult_arbiter #(
    .bit_width (8),
    .num_req   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 4'b0;
    resp_ready = 4'hF;
    tick();
    rst = 1'b0;
  endtask

  // Reference arbitration: first valid requester scanning from p, wrapping.
  function automatic int rr_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    req_a      = 32'h0102_0304;
    req_b      = 32'h0506_0708;
    tick();
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0) begin
      n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    n_cmp++;
    if (resp_valid !== 4'b0) begin
      n_err++; $display("FAIL reset_resp_valid got %b want 0000", resp_valid);
    end
    n_cmp++;
    if (resp_result !== 8'd0) begin
      n_err++; $display("FAIL reset_resp_result got %0d want 0", resp_result);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", busy);
    end
    rst       = 1'b0;
    req_valid = 4'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 7, 9);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_grant got ready=%b busy=%b want 0001/0", req_ready, busy);
    end
    tick();
    req_valid = 4'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 4'b0 || req_ready !== 4'b0) begin
      n_err++; $display("FAIL single_calc got busy=%b rv=%b rr=%b want 1/0000/0000", busy, resp_valid, req_ready);
    end
    tick();
    #1;
    n_cmp++;
    if (busy !== 1'b1 || resp_valid !== 4'b0001 || resp_result !== 8'd63) begin
      n_err++; $display("FAIL single_resp got busy=%b rv=%b res=%0d want 1/0001/63", busy, resp_valid, resp_result);
    end
    tick();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 4'b0 || resp_result !== 8'd63) begin
      n_err++; $display("FAIL single_done got busy=%b rv=%b res=%0d want 0/0000/63", busy, resp_valid, resp_result);
    end
  endtask

  task automatic test_overflow();
    int av [3] = '{200, 255, 0};
    int bv [3] = '{3, 255, 123};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      set_req(2, av[n], bv[n]);
      req_valid = 4'b0100;
      #1;
      n_cmp++;
      if (req_ready !== 4'b0100) begin
        n_err++; $display("FAIL overflow_grant%0d got %b want 0100", n, req_ready);
      end
      tick();
      req_valid = 4'b0;
      tick();
      #1;
      n_cmp++;
      if (resp_valid !== 4'b0100 || resp_result !== 8'((av[n] * bv[n]) % 256)) begin
        n_err++; $display("FAIL overflow_result%0d got rv=%b res=%0d want 0100/%0d",
                          n, resp_valid, resp_result, (av[n] * bv[n]) % 256);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int p;
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i + 1, 10);
    req_valid = 4'hF;
    p = 0;
    for (int n = 0; n < 5; n++) begin
      g = rr_pick(p, 4'hF);
      #1;
      n_cmp++;
      if (req_ready !== oh(g)) begin
        n_err++; $display("FAIL rr_grant%0d got %b want %b", n, req_ready, oh(g));
      end
      tick();
      #1;
      n_cmp++;
      if (req_ready !== 4'b0) begin
        n_err++; $display("FAIL rr_calc_ready%0d got %b want 0000", n, req_ready);
      end
      tick();
      #1;
      n_cmp++;
      if (resp_valid !== oh(g) || resp_result !== 8'((g + 1) * 10)) begin
        n_err++; $display("FAIL rr_result%0d got rv=%b res=%0d want %b/%0d",
                          n, resp_valid, resp_result, oh(g), (g + 1) * 10);
      end
      tick();
      p = (g + 1) % 4;
    end
    req_valid = 4'b0;
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_req(1, 2, 3);
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL skip_first got %b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b0;
    tick();
    tick();
    set_req(0, 4, 4);
    set_req(3, 5, 5);
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL skip_grant3 got %b want 1000", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    tick();
    #1;
    n_cmp++;
    if (resp_valid !== 4'b1000 || resp_result !== 8'd25) begin
      n_err++; $display("FAIL skip_res3 got rv=%b res=%0d want 1000/25", resp_valid, resp_result);
    end
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL skip_grant0 got %b want 0001", req_ready);
    end
    tick();
    req_valid = 4'b0;
    tick();
    #1;
    n_cmp++;
    if (resp_valid !== 4'b0001 || resp_result !== 8'd16) begin
      n_err++; $display("FAIL skip_res0 got rv=%b res=%0d want 0001/16", resp_valid, resp_result);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 5, 6);
    set_req(1, 3, 4);
    req_valid = 4'b0001;
    tick();
    req_valid  = 4'b0010;
    resp_ready = 4'b1110;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (resp_result !== 8'd30 || resp_valid !== 4'b0001 || req_ready !== 4'b0) begin
        n_err++; $display("FAIL bp_hold%0d got res=%0d rv=%b rr=%b want 30/0001/0000",
                          k, resp_result, resp_valid, req_ready);
      end
      tick();
    end
    resp_ready = 4'b0001;
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010 || resp_valid !== 4'b0 || resp_result !== 8'd30) begin
      n_err++; $display("FAIL bp_after got rr=%b rv=%b res=%0d want 0010/0000/30",
                        req_ready, resp_valid, resp_result);
    end
    tick();
    req_valid  = 4'b0;
    resp_ready = 4'hF;
    tick();
    #1;
    n_cmp++;
    if (resp_valid !== 4'b0010 || resp_result !== 8'd12) begin
      n_err++; $display("FAIL bp_second got rv=%b res=%0d want 0010/12", resp_valid, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 10, 10);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0;
    rst       = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0) begin
      n_err++; $display("FAIL mid_rst_ready got %b want 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 4'b0 || resp_result !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_out got rv=%b res=%0d busy=%b want 0000/0/0",
                        resp_valid, resp_result, busy);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (resp_valid !== 4'b0) begin
        n_err++; $display("FAIL mid_rst_ghost%0d got rv=%b want 0000", k, resp_valid);
      end
    end
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_rst_ptr got %b want 0001", req_ready);
    end
    req_valid = 4'b0;
    #1;
  endtask

  task automatic test_random();
    bit   pend [4];
    int   pa   [4];
    int   pb   [4];
    int   p;
    int   g;
    int   d;
    int   expv;
    logic [3:0] rnd;
    do_reset();
    p = 0;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    for (int op = 0; op < 40; op++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i]   = int'($urandom_range(0, 255));
          pb[i]   = int'($urandom_range(0, 255));
          set_req(i, pa[i], pb[i]);
        end
        req_valid[i] = pend[i];
      end
      #1;
      g = rr_pick(p, req_valid);
      if (g < 0) begin
        n_cmp++;
        if (req_ready !== 4'b0 || busy !== 1'b0) begin
          n_err++; $display("FAIL rnd_idle%0d got rr=%b busy=%b want 0000/0", op, req_ready, busy);
        end
        tick();
        continue;
      end
      n_cmp++;
      if (req_ready !== oh(g)) begin
        n_err++; $display("FAIL rnd_grant%0d got %b want %b", op, req_ready, oh(g));
      end
      tick();
      pend[g]      = 1'b0;
      req_valid[g] = 1'b0;
      p            = (g + 1) % 4;
      expv         = (pa[g] * pb[g]) % 256;
      rnd          = 4'($urandom_range(0, 15));
      resp_ready   = rnd & ~oh(g);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || resp_valid !== 4'b0) begin
        n_err++; $display("FAIL rnd_calc%0d got busy=%b rv=%b want 1/0000", op, busy, resp_valid);
      end
      tick();
      d = int'($urandom_range(0, 3));
      for (int k = 0; k <= d; k++) begin
        #1;
        n_cmp++;
        if (resp_valid !== oh(g) || resp_result !== 8'(expv)) begin
          n_err++; $display("FAIL rnd_resp%0d got rv=%b res=%0d want %b/%0d",
                            op, resp_valid, resp_result, oh(g), expv);
        end
        rnd        = 4'($urandom_range(0, 15));
        resp_ready = (k < d) ? (rnd & ~oh(g)) : (rnd | oh(g));
        tick();
      end
      #1;
      n_cmp++;
      if (resp_valid !== 4'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rnd_accept%0d got rv=%b busy=%b want 0000/0", op, resp_valid, busy);
      end
    end
    req_valid  = 4'b0;
    resp_ready = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    req_valid  = 4'b0;
    resp_ready = 4'hF;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_pointer_skip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
